// File: rtl/encoder16_4_seq_if.sv
// encoder16_4_seq_if: word-in / code-out handshake bundle for the sequential 16-to-4 encoder
interface encoder16_4_seq_if;
  logic        e;
  logic [15:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        zero_err;
  logic [4:0]  cnt;
  modport master (output e, d, in_valid, out_ready, input in_ready, a, out_valid, out_last, zero_err, cnt);
  modport slave  (input e, d, in_valid, out_ready, output in_ready, a, out_valid, out_last, zero_err, cnt);
endinterface

// File: rtl/encoder16_4_seq.sv
// encoder16_4_seq: emits the 4-bit index of every set bit of a captured 16-bit word, in priority order
module encoder16_4_seq #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  encoder16_4_seq_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d, nxt;
  logic [3:0]  a_q, a_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d, zero_err_q, zero_err_d;
  logic [4:0]  cnt_q, cnt_d;
  function automatic logic [3:0] prio(input logic [15:0] x);
    logic [3:0] p;
    p = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 16; i++) if (x[i]) p = 4'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (x[i]) p = 4'(i);
    end
    return p;
  endfunction
  function automatic logic single(input logic [15:0] x);
    return (x != '0) && ((x & (x - 16'd1)) == '0);
  endfunction
  assign bus.in_ready  = (state_q == IDLE) && bus.e;
  assign bus.a         = a_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.zero_err  = zero_err_q;
  assign bus.cnt       = cnt_q;
  assign nxt = pending_q & ~(16'd1 << a_q);
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    zero_err_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.in_valid && bus.in_ready) begin
        if (bus.d != '0) begin
          pending_d   = bus.d;
          a_d         = prio(bus.d);
          out_valid_d = 1'b1;
          out_last_d  = single(bus.d);
          cnt_d       = '0;
          state_d     = BUSY;
        end else zero_err_d = 1'b1;
      end
    end else if (!bus.e) begin
      // abort wins over a same-cycle handshake; the code on a is dropped uncounted
      pending_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      state_d     = IDLE;
    end else if (out_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + 5'd1;
      if (nxt == '0) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end else begin
        pending_d  = nxt;
        a_d        = prio(nxt);
        out_last_d = single(nxt);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      zero_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      zero_err_q  <= zero_err_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: doc/encoder16_4_seq.md
Name: encoder16_4_seq

Overview:
- Sequential 16-to-4 encoder; the inverse of the team's 4-to-16 decoder (code {a1,a2,a3,w} = 4'b1111 selects d[15]).
- Accepts a 16-bit word of asserted lines over a valid/ready handshake.
- Emits the 4-bit index of every set bit, one code per accepted output handshake, in priority order, with a last-code marker.
- Used to turn request/selection vectors back into addresses for the decoder side.

Parameters:
- MSB_FIRST, 1, priority order: 1 = highest set index emitted first, 0 = lowest first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- e  input  1  enable; low blocks capture and aborts a word in progress.
- d  input  16  input line vector.
- in_valid  input  1  d is valid this cycle.
- in_ready  output  1  block can accept d; combinational, equals (state==IDLE) && e.
- a  output  4  encoded index, registered.
- out_valid  output  1  a is valid, registered.
- out_last  output  1  a is the final code of the current word, registered.
- out_ready  input  1  consumer accepts a this cycle.
- zero_err  output  1  one-cycle pulse, registered: an all-zero word was accepted.
- cnt  output  5  number of codes emitted for the current word, registered, range 0..16.

Behaviour:
- Reset: state IDLE; pending=0; a=0; out_valid=0; out_last=0; zero_err=0; cnt=0.
  - rst is synchronous and overrides every other input at that edge, including mid-word.
  - No code is emitted after reset.
- States:
  - IDLE: waiting for a word.
  - BUSY: pending holds the bits not yet emitted.
- Priority function P(x): index of highest set bit if MSB_FIRST=1, else index of lowest set bit. onehot(i) = 16'b1 << i.
- IDLE, capture condition in_valid && in_ready:
  - If d != 0: pending<=d; a<=P(d); out_valid<=1; out_last<=(popcount(d)==1); cnt<=0; state<=BUSY.
  - Latency: first code is valid one cycle after the capture edge.
  - If d == 0: zero_err<=1 for exactly one cycle; state stays IDLE; out_valid stays 0.
- BUSY, abort: if e==0, at the next edge pending<=0, out_valid<=0, out_last<=0, state<=IDLE, cnt unchanged. Abort has priority over a simultaneous out_valid && out_ready handshake; the code on a is not counted.
- BUSY, handshake out_valid && out_ready with e==1:
  - nxt = pending & ~onehot(a); cnt<=cnt+1.
  - If nxt==0: out_valid<=0; out_last<=0; state<=IDLE.
  - Else: pending<=nxt; a<=P(nxt); out_last<=(popcount(nxt)==1).
- BUSY, stall (out_ready=0, e=1): a, out_valid, out_last and pending are held stable.
- Throughput: one code per cycle while out_ready=1.
  - in_ready is 0 during BUSY, including the cycle of the final handshake.
  - The next word can be captured no earlier than the cycle after returning to IDLE.
  - Minimum cost of a word with k set bits: k+1 cycles.
- a holds its last value when out_valid=0. cnt holds until the next word is captured.
- in_valid while in_ready=0: ignored, no state change.

Test Plan:
- Reset mid-word: capture d=16'h8421, take 1 code, assert rst for 1 cycle -> out_valid=0, a=0, cnt=0, in_ready=1 after reset.
- Single bit: e=1, capture d=16'h8000 -> next cycle a=4'hF, out_valid=1, out_last=1. With out_ready=1 -> out_valid=0 next cycle, cnt=1, in_ready=1 one cycle later.
- Multi-bit, MSB_FIRST=1, out_ready held 1: d=16'h8421 -> a sequence F,A,5,0 on consecutive cycles, out_last only with 0, cnt=4. Repeat with MSB_FIRST=0 -> sequence 0,5,A,F.
- Backpressure: d=16'h0003, out_ready=0 for 3 cycles -> a=1 held stable with out_valid=1. Then out_ready=1 -> a=0 with out_last=1, then idle.
- Zero word and enable: capture d=16'h0000 -> zero_err high for exactly 1 cycle, out_valid stays 0. With e=0 and in_valid=1, d=16'hFFFF -> in_ready=0, nothing captured.
- Abort: capture d=16'hFFFF, after 2 codes drive e=0 together with out_ready=1 -> out_valid=0 next cycle, cnt=2, state IDLE.
